// File: rtl/life_pkg.sv
// Shared geometry, encodings and toroidal index helpers for the Life generation scheduler.
package life_pkg;

  localparam int unsigned GRID_W = 16;
  localparam int unsigned GRID_H = 16;
  localparam int unsigned CELLS  = GRID_W * GRID_H;
  localparam int unsigned X_W    = $clog2(GRID_W);
  localparam int unsigned Y_W    = $clog2(GRID_H);
  localparam int unsigned ADDR_W = X_W + Y_W;
  localparam int unsigned GEN_W  = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    OP_TOGGLE = 2'd0,
    OP_CLEAR  = 2'd1,
    OP_LOAD   = 2'd2,
    OP_RSVD   = 2'd3
  } edit_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    EVAL   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  typedef logic [GRID_W-1:0] row_t;
  typedef logic [CELLS-1:0]  map_t;

  // Grid dimensions are powers of two, so truncation gives the modulo wrap.
  function automatic logic [X_W-1:0] wrap_x(input logic [X_W-1:0] x, input int d);
    return X_W'(int'(x) + d);
  endfunction

  function automatic logic [Y_W-1:0] wrap_y(input logic [Y_W-1:0] y, input int d);
    return Y_W'(int'(y) + d);
  endfunction

  function automatic row_t row_of(input map_t m, input logic [Y_W-1:0] y);
    return m[y*GRID_W +: GRID_W];
  endfunction

endpackage

// File: rtl/life_gen_scheduler_if.sv
// Edit request channel between the button/switch front end and the scheduler.
interface life_gen_scheduler_if;
  import life_pkg::*;

  logic              edit_req;
  edit_op_t          edit_op;
  logic [ADDR_W-1:0] edit_addr;
  map_t              load_data;
  logic              edit_ack;

  modport master (output edit_req, edit_op, edit_addr, load_data, input edit_ack);
  modport slave  (input edit_req, edit_op, edit_addr, load_data, output edit_ack);
endinterface

// File: rtl/life_row_eval.sv
// Combinational next-state for one row of the toroidal Life grid.
module life_row_eval
  import life_pkg::*;
(
  input  row_t row_up,
  input  row_t row_mid,
  input  row_t row_dn,
  output row_t row_next
);

  for (genvar x = 0; x < GRID_W; x++) begin : g_col
    localparam logic [X_W-1:0] XC = X_W'(x);
    localparam logic [X_W-1:0] XL = wrap_x(XC, -1);
    localparam logic [X_W-1:0] XR = wrap_x(XC, 1);

    // Four bits: a full neighbourhood of 8 must not alias to 0.
    logic [CNT_W-1:0] cnt;

    assign cnt = CNT_W'(row_up[XL])  + CNT_W'(row_up[XC])  + CNT_W'(row_up[XR])
               + CNT_W'(row_mid[XL])                       + CNT_W'(row_mid[XR])
               + CNT_W'(row_dn[XL])  + CNT_W'(row_dn[XC])  + CNT_W'(row_dn[XR]);

    assign row_next[x] = (cnt == CNT_W'(3)) | (row_mid[XC] & (cnt == CNT_W'(2)));
  end

endmodule

// File: rtl/life_gen_scheduler.sv
// Owns the Life map; arbitrates edits against generation requests and evaluates one row per cycle.
module life_gen_scheduler
  import life_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 run,
  input  logic                 step_req,
  life_gen_scheduler_if.slave  edit,
  output map_t                 map,
  output logic                 busy,
  output logic                 gen_done,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 overrun
);

  state_t           state, state_d;
  logic [Y_W-1:0]   row, row_d;
  logic             pend, pend_d;
  map_t             shadow, shadow_d;
  map_t             map_d;
  logic [GEN_W-1:0] gen_count_d;
  logic             overrun_d, busy_d, gen_done_d;
  logic             edit_ack_q, edit_ack_d;
  logic             request_c;
  row_t             row_next_c;

  assign request_c     = (tick & run) | (step_req & ~run);
  assign edit.edit_ack = edit_ack_q;

  life_row_eval u_row_eval (
    .row_up   (row_of(map, wrap_y(row, -1))),
    .row_mid  (row_of(map, row)),
    .row_dn   (row_of(map, wrap_y(row, 1))),
    .row_next (row_next_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    row_d       = row;
    pend_d      = pend;
    shadow_d    = shadow;
    map_d       = map;
    gen_count_d = gen_count;
    overrun_d   = overrun;
    edit_ack_d  = 1'b0;
    gen_done_d  = 1'b0;

    case (state)
      IDLE: begin
        if (pend) begin
          state_d = EVAL;
          row_d   = '0;
          pend_d  = request_c;
        end else if (edit.edit_req) begin
          state_d    = EDIT;
          edit_ack_d = 1'b1;
          pend_d     = request_c;
          case (edit.edit_op)
            OP_TOGGLE: map_d[edit.edit_addr] = ~map[edit.edit_addr];
            OP_CLEAR: begin
              map_d       = '0;
              gen_count_d = '0;
            end
            OP_LOAD: begin
              map_d       = edit.load_data;
              gen_count_d = '0;
            end
            default: ;
          endcase
        end else if (request_c) begin
          state_d = EVAL;
          row_d   = '0;
        end
      end
      EDIT: state_d = IDLE;
      EVAL: begin
        shadow_d[row*GRID_W +: GRID_W] = row_next_c;
        if (row == Y_W'(GRID_H - 1)) begin
          state_d    = COMMIT;
          gen_done_d = 1'b1;
        end else begin
          row_d = Y_W'(row + 1'b1);
        end
      end
      COMMIT: begin
        map_d       = shadow;
        gen_count_d = GEN_W'(gen_count + 1'b1);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // One-deep pending slot while the map is owned by an edit or a generation.
    if (request_c && state != IDLE) begin
      if (pend) overrun_d = 1'b1;
      else      pend_d    = 1'b1;
    end

    busy_d = (state_d == EVAL) || (state_d == COMMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      row        <= '0;
      pend       <= 1'b0;
      shadow     <= '0;
      map        <= '0;
      gen_count  <= '0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
      gen_done   <= 1'b0;
      edit_ack_q <= 1'b0;
    end else begin
      state      <= state_d;
      row        <= row_d;
      pend       <= pend_d;
      shadow     <= shadow_d;
      map        <= map_d;
      gen_count  <= gen_count_d;
      overrun    <= overrun_d;
      busy       <= busy_d;
      gen_done   <= gen_done_d;
      edit_ack_q <= edit_ack_d;
    end
  end

endmodule

// File: doc/life_gen_scheduler.md
Name: life_gen_scheduler

Overview:
- Owns the 16x16 toroidal Life map and sequences each generation row-serially, one row per cycle.
- Arbitrates map access between rate-divider ticks and user edit requests (toggle cell, clear, pattern/random load).
- Sits between the debounced button/switch logic, the rate-divided tick source, and the display/LED consumers of the map.

Parameters:
- GRID_W, 16, columns; power of two; x = index[3:0].
- GRID_H, 16, rows; power of two; y = index[7:4].
- GEN_W, 16, width of generation counter.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle strobe requesting one generation; honoured only while run=1.
- run  in  1  level; 1 = free-run on tick, 0 = stopped.
- step_req  in  1  one-cycle strobe; single generation while run=0; ignored while run=1.
- edit_req  in  1  held high until edit_ack.
- edit_op  in  2  0 = TOGGLE, 1 = CLEAR, 2 = LOAD, 3 = reserved (acked, no effect).
- edit_addr  in  8  cell index y*16+x for TOGGLE.
- load_data  in  256  full map image for LOAD.
- edit_ack  out  1  one-cycle pulse in the cycle the edit is applied.
- map  out  256  current generation; bit i = cell (i%16, i/16).
- busy  out  1  high in EVAL and COMMIT.
- gen_done  out  1  one-cycle pulse in the COMMIT cycle.
- gen_count  out  GEN_W  generations committed since reset/CLEAR/LOAD; wraps modulo 2^GEN_W.
- overrun  out  1  sticky: a request arrived while pend was already set.

Behaviour:
- Reset (async, rst_n=0): map=0, gen_count=0, state=IDLE, pend=0, edit_ack=0, gen_done=0, overrun=0, busy=0.
- Request = (tick & run) | (step_req & ~run).
- States:
  - IDLE: if edit_req -> EDIT. Else if request or pend -> EVAL, row=0, pend cleared.
  - EDIT: 1 cycle; apply op; edit_ack=1 -> IDLE.
  - EVAL: row 0..15, one per cycle; row 15 -> COMMIT.
  - COMMIT: 1 cycle; map<=shadow; gen_count+1; gen_done=1 -> IDLE.
- EVAL datapath:
  - For each x in the row, count the 8 neighbours of the frozen map with wrap: x±1 mod 16, y±1 mod 16.
  - Count is 4 bits (0..8); a 3-bit count is forbidden because 8 aliases to 0.
  - next = (count==3) | (cell & count==2); result written to shadow row.
  - map is unchanged during EVAL; all reads see generation N.
- Latency: request accepted in IDLE at cycle t -> EVAL t+1..t+16 -> COMMIT t+17 -> new map visible t+18.
- Request while in EDIT/EVAL/COMMIT: pend<=1 (one deep). Request while pend already set: dropped, overrun<=1.
- Simultaneous edit_req and request in IDLE: edit wins, request sets pend. pend is serviced before a later edit_req.
- edit_req during EVAL/COMMIT: held off, not acked until back in IDLE (and after pend is serviced).
- CLEAR: map=0, gen_count=0. LOAD: map=load_data, gen_count=0. TOGGLE: map[edit_addr] inverted.
- run dropping mid-generation: current generation completes; pend is still serviced.
- Reset asserted mid-EVAL: immediate return to reset values; shadow contents irrelevant.
- overrun clears only on reset.

Decomposition:
- Package life_pkg: GRID_W/GRID_H, edit_op encodings (OP_TOGGLE, OP_CLEAR, OP_LOAD), state encoding (IDLE, EDIT, EVAL, COMMIT), toroidal index helpers wrap_x/wrap_y.
- Sub-module life_row_eval (combinational): inputs rows y-1, y, y+1 (16 bits each); output next row (16 bits). The scheduler handles row selection, shadow, FSM, and arbitration.

Test Plan:
- Blinker: LOAD cells 17,18,19; tick with run=1 -> at t+18 map has exactly 2,18,34; gen_done at t+17; gen_count=1; second tick restores 17,18,19.
- Wrap: LOAD glider 0,17,18,32,33; 64 ticks -> identical pattern back at original cells, gen_count=64, no bits lost at edges.
- Pend/overrun: tick at t, second tick at t+5, third at t+6 -> two generations committed (gen_done at t+17 and t+35), overrun=1.
- Arbitration: edit_req TOGGLE addr 0x35 and tick in the same IDLE cycle -> edit_ack next cycle with map[53] flipped, then EVAL starts; a mid-EVAL edit_req is acked only after COMMIT.
- Full-neighbour count: LOAD 3x3 block of all ones centred at 0x88 -> after one generation the centre cell is 0 (count 8) and the four corners are 1.
- Reset mid-EVAL: rst_n low at EVAL row 7 -> map=0, busy=0, gen_count=0 immediately; no gen_done after release.
